// File: rtl/ipf_window_feeder_if.sv
// ipf_window_feeder_if: control, row-input and window-output signals of the IPF window feeder.
interface ipf_window_feeder_if #(
   parameter int PIX_W = 8,
   parameter int LANES = 8,
   parameter int MAX_K = 7,
   parameter int ROW_W = 16
);
   logic [1:0] ctrl;
   logic [1:0] Wsize;
   logic stride;
   logic [1:0] RLPadding;
   logic i_valid;
   logic i_ready;
   logic [LANES*PIX_W-1:0] i_data;
   logic res_valid;
   logic res_ready;
   logic [MAX_K*MAX_K*PIX_W-1:0] result;
   logic res_last;
   logic [3:0] res_col;
   logic [ROW_W-1:0] res_row;
   modport master (
      output ctrl, Wsize, stride, RLPadding, i_valid, i_data, res_ready,
      input i_ready, res_valid, result, res_last, res_col, res_row
   );
   modport slave (
      input ctrl, Wsize, stride, RLPadding, i_valid, i_data, res_ready,
      output i_ready, res_valid, result, res_last, res_col, res_row
   );
endinterface

// File: rtl/ipf_window_feeder.sv
// ipf_window_feeder: keeps the last K rows and streams KxK windows per row band into the IPF multiply array.
module ipf_window_feeder #(
   parameter int PIX_W = 8,
   parameter int LANES = 8,
   parameter int MAX_K = 7,
   parameter int ROW_W = 16
) (
   input logic clk,
   input logic rst,
   ipf_window_feeder_if.slave bus
);
   localparam int RW = LANES * PIX_W;
   localparam int WW = MAX_K * MAX_K * PIX_W;
   localparam int KW = $clog2(MAX_K);
   typedef enum logic [1:0] {IDLE, ACCEPT, EMIT, HOLD} state_t;
   state_t state_q, state_d, ret_q, ret_d;
   logic [RW-1:0] buf_q [MAX_K];
   logic [RW-1:0] buf_d [MAX_K];
   logic [2:0] k_q, k_d, cnt_q, cnt_d, p;
   logic str_q, str_d, since_q, since_d, band;
   logic [1:0] pad_q, pad_d;
   logic [3:0] col_q, col_d, last_col;
   logic [ROW_W-1:0] row_q, row_d;
   logic [WW-1:0] win, res_q;
   int pl;
   assign p = (k_q - 3'd1) >> 1;
   assign pl = pad_q[0] ? int'(p) : 0;
   assign last_col = 4'((LANES + int'(p) * (int'(pad_q[0]) + int'(pad_q[1])) - int'(k_q)) >> str_q);
   // since_q marks that one row of a stride-2 step has already arrived
   assign band = (cnt_q == k_q - 3'd1) || (cnt_q == k_q && (!str_q || since_q));
   assign bus.i_ready = state_q == ACCEPT;
   assign bus.res_valid = state_q == EMIT;
   assign bus.res_last = state_q == EMIT && col_q == last_col;
   assign bus.res_col = col_q;
   assign bus.res_row = row_q;
   assign bus.result = res_q;
   always_comb begin
      state_d = state_q;
      ret_d = ret_q;
      k_d = k_q;
      str_d = str_q;
      pad_d = pad_q;
      buf_d = buf_q;
      cnt_d = cnt_q;
      since_d = since_q;
      col_d = col_q;
      row_d = row_q;
      case (state_q)
         IDLE: if (bus.ctrl == 2'd1) begin
            k_d = bus.Wsize == 2'd1 ? 3'd5 : bus.Wsize == 2'd2 ? 3'd7 : 3'd3;
            str_d = bus.stride;
            pad_d = bus.RLPadding;
            state_d = ACCEPT;
         end
         ACCEPT: if (bus.i_valid) begin
            buf_d[0] = bus.i_data;
            for (int i = 1; i < MAX_K; i++) buf_d[KW'(i)] = buf_q[KW'(i - 1)];
            cnt_d = cnt_q == k_q ? k_q : cnt_q + 3'd1;
            since_d = !band;
            col_d = '0;
            state_d = band ? EMIT : ACCEPT;
         end
         EMIT: if (bus.res_ready) begin
            col_d = col_q == last_col ? 4'd0 : col_q + 4'd1;
            row_d = col_q == last_col ? row_q + ROW_W'(1) : row_q;
            state_d = col_q == last_col ? ACCEPT : EMIT;
         end
         default: if (bus.ctrl == 2'd1) state_d = ret_q;
      endcase
      // a transfer already offered this cycle completes before parking in HOLD
      if (bus.ctrl[1] && (state_q == ACCEPT || state_q == EMIT)) begin
         ret_d = state_d;
         state_d = HOLD;
      end
      if (bus.ctrl == 2'd0) begin
         state_d = IDLE;
         buf_d = '{default: '0};
         cnt_d = '0;
         since_d = 1'b0;
         col_d = '0;
         row_d = '0;
      end
   end
   always_comb begin
      int x;
      x = 0;
      win = '0;
      for (int r = 0; r < MAX_K; r++)
         for (int c = 0; c < MAX_K; c++) begin
            x = (int'(col_d) << str_q) + c - pl;
            if (r < int'(k_q) && c < int'(k_q) && x >= 0 && x < LANES)
               win = win | (WW'(PIX_W'(buf_d[KW'(int'(k_q) - 1 - r)] >> (x * PIX_W))) << ((r * MAX_K + c) * PIX_W));
         end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ret_q <= IDLE;
         k_q <= 3'd3;
         str_q <= 1'b0;
         pad_q <= '0;
         buf_q <= '{default: '0};
         cnt_q <= '0;
         since_q <= 1'b0;
         col_q <= '0;
         row_q <= '0;
         res_q <= '0;
      end else begin
         state_q <= state_d;
         ret_q <= ret_d;
         k_q <= k_d;
         str_q <= str_d;
         pad_q <= pad_d;
         buf_q <= buf_d;
         cnt_q <= cnt_d;
         since_q <= since_d;
         col_q <= col_d;
         row_q <= row_d;
         res_q <= win;
      end
   end
endmodule

// File: tb/tb_ipf_window_feeder.sv
// tb_ipf_window_feeder: directed scenarios for the window feeder with hand-computed window contents.
module tb_ipf_window_feeder;
   localparam int PIX_W = 8, LANES = 8, MAX_K = 7, ROW_W = 16;
   localparam int RW = LANES * PIX_W, WW = MAX_K * MAX_K * PIX_W;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0, errors = 0;
   logic [WW-1:0] wv [16];
   logic [3:0] wc [16];
   logic wl [16];
   logic [ROW_W-1:0] wr [16];
   int nw;
   ipf_window_feeder_if #(.PIX_W(PIX_W), .LANES(LANES), .MAX_K(MAX_K), .ROW_W(ROW_W)) bus ();
   ipf_window_feeder #(.PIX_W(PIX_W), .LANES(LANES), .MAX_K(MAX_K), .ROW_W(ROW_W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end
   function automatic logic [7:0] el(input logic [WW-1:0] w, input int r, input int c);
      logic [WW-1:0] t;
      t = w >> ((r * MAX_K + c) * PIX_W);
      return t[7:0];
   endfunction
   function automatic logic [RW-1:0] row(input int n);
      logic [RW-1:0] d;
      d = '0;
      for (int q = 0; q < LANES; q++) d = d | (RW'(8'(n * 16 + q)) << (q * PIX_W));
      return d;
   endfunction
   task automatic send_row(input int n);
      bus.i_data = row(n);
      for (int i = 0; i < 50; i++) begin
         if (bus.i_ready) begin
            bus.i_valid = 1'b1;
            @(negedge clk);
            bus.i_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      checks++; errors++;
      $display("FAIL send_row_%0d: i_ready got 0 need 1 within 50 cycles", n);
   endtask
   task automatic drain();
      nw = 0;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (bus.res_valid && nw < 16) begin
            wv[nw] = bus.result; wc[nw] = bus.res_col; wl[nw] = bus.res_last; wr[nw] = bus.res_row;
            nw++;
            if (bus.res_last) return;
         end
         @(negedge clk);
      end
      checks++; errors++;
      $display("FAIL drain: res_last got 0 need 1 within 60 cycles");
   endtask
   task automatic start(input logic [1:0] ws, input logic st, input logic [1:0] pad);
      bus.ctrl = 2'd0;
      @(negedge clk);
      bus.Wsize = ws; bus.stride = st; bus.RLPadding = pad; bus.ctrl = 2'd1;
      @(negedge clk);
   endtask
   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if ({bus.i_ready, bus.res_valid, bus.res_last, bus.res_col} !== 7'd0) begin errors++; $display("FAIL reset_flags: got %b need 0", {bus.i_ready, bus.res_valid, bus.res_last, bus.res_col}); end
      checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result: got %h need 0", bus.result); end
      checks++; if (bus.res_row !== '0) begin errors++; $display("FAIL reset_row: got %0d need 0", bus.res_row); end
      rst = 1'b0;
   endtask
   task automatic test_basic();
      start(2'd0, 1'b0, 2'd0);
      for (int n = 0; n < 3; n++) send_row(n);
      checks++; if ({bus.res_valid, bus.i_ready} !== 2'b10) begin errors++; $display("FAIL basic_emit_state: got %b need 10", {bus.res_valid, bus.i_ready}); end
      drain();
      checks++; if (nw !== 6) begin errors++; $display("FAIL basic_count: got %0d need 6", nw); end
      for (int j = 0; j < 6; j++) begin
         checks++; if ({wc[j], wl[j], wr[j]} !== {4'(j), j == 5, 16'd0}) begin errors++; $display("FAIL basic_seq_%0d: got col %0d last %b row %0d need col %0d last %b row 0", j, wc[j], wl[j], wr[j], j, j == 5); end
      end
      checks++; if (el(wv[0], 0, 0) !== 8'h00) begin errors++; $display("FAIL basic_w0_00: got %h need 00", el(wv[0], 0, 0)); end
      checks++; if (el(wv[0], 2, 2) !== 8'h22) begin errors++; $display("FAIL basic_w0_22: got %h need 22", el(wv[0], 2, 2)); end
      checks++; if (el(wv[5], 2, 2) !== 8'h27) begin errors++; $display("FAIL basic_w5_22: got %h need 27", el(wv[5], 2, 2)); end
      checks++; if (el(wv[0], 3, 3) !== 8'h00) begin errors++; $display("FAIL basic_unused: got %h need 00", el(wv[0], 3, 3)); end
      send_row(3);
      drain();
      checks++; if ({nw[3:0], wr[0]} !== {4'd6, 16'd1}) begin errors++; $display("FAIL basic_band1: got count %0d row %0d need 6 1", nw, wr[0]); end
      checks++; if (el(wv[0], 0, 0) !== 8'h10) begin errors++; $display("FAIL basic_band1_00: got %h need 10", el(wv[0], 0, 0)); end
   endtask
   task automatic test_padding();
      start(2'd0, 1'b0, 2'd3);
      for (int n = 0; n < 3; n++) send_row(n);
      drain();
      checks++; if (nw !== 8) begin errors++; $display("FAIL pad_count: got %0d need 8", nw); end
      checks++; if ((el(wv[0], 0, 0) | el(wv[0], 1, 0) | el(wv[0], 2, 0)) !== 8'h00) begin errors++; $display("FAIL pad_left_col: got nonzero need 00"); end
      checks++; if (el(wv[0], 1, 1) !== 8'h10) begin errors++; $display("FAIL pad_w0_11: got %h need 10", el(wv[0], 1, 1)); end
      checks++; if ((el(wv[7], 0, 2) | el(wv[7], 1, 2) | el(wv[7], 2, 2)) !== 8'h00) begin errors++; $display("FAIL pad_right_col: got nonzero need 00"); end
      checks++; if ({el(wv[7], 0, 0), wl[7]} !== {8'h06, 1'b1}) begin errors++; $display("FAIL pad_w7: got %h last %b need 06 1", el(wv[7], 0, 0), wl[7]); end
      start(2'd0, 1'b0, 2'd1);
      for (int n = 0; n < 3; n++) send_row(n);
      drain();
      checks++; if (nw !== 7) begin errors++; $display("FAIL lpad_count: got %0d need 7", nw); end
      checks++; if (el(wv[6], 0, 2) !== 8'h07) begin errors++; $display("FAIL lpad_w6_02: got %h need 07", el(wv[6], 0, 2)); end
   endtask
   task automatic test_stride();
      start(2'd0, 1'b1, 2'd0);
      for (int n = 0; n < 3; n++) send_row(n);
      drain();
      checks++; if (nw !== 3) begin errors++; $display("FAIL stride_count: got %0d need 3", nw); end
      checks++; if (el(wv[1], 0, 0) !== 8'h02) begin errors++; $display("FAIL stride_w1_00: got %h need 02", el(wv[1], 0, 0)); end
      checks++; if ({wc[2], el(wv[2], 2, 2)} !== {4'd2, 8'h26}) begin errors++; $display("FAIL stride_w2: got col %0d el %h need 2 26", wc[2], el(wv[2], 2, 2)); end
      send_row(3);
      checks++; if ({bus.res_valid, bus.i_ready} !== 2'b01) begin errors++; $display("FAIL stride_skip: got %b need 01", {bus.res_valid, bus.i_ready}); end
      send_row(4);
      drain();
      checks++; if ({el(wv[0], 0, 0), wr[0]} !== {8'h20, 16'd1}) begin errors++; $display("FAIL stride_band1: got %h row %0d need 20 1", el(wv[0], 0, 0), wr[0]); end
   endtask
   task automatic test_big_kernels();
      start(2'd1, 1'b0, 2'd0);
      for (int n = 0; n < 5; n++) send_row(n);
      drain();
      checks++; if (nw !== 4) begin errors++; $display("FAIL k5_count: got %0d need 4", nw); end
      checks++; if (el(wv[0], 4, 4) !== 8'h44) begin errors++; $display("FAIL k5_w0_44: got %h need 44", el(wv[0], 4, 4)); end
      checks++; if ((el(wv[0], 0, 5) | el(wv[0], 5, 0) | el(wv[0], 6, 6)) !== 8'h00) begin errors++; $display("FAIL k5_unused: got nonzero need 00"); end
      checks++; if ({el(wv[3], 4, 4), wl[3]} !== {8'h47, 1'b1}) begin errors++; $display("FAIL k5_w3: got %h last %b need 47 1", el(wv[3], 4, 4), wl[3]); end
      start(2'd2, 1'b0, 2'd0);
      for (int n = 0; n < 6; n++) send_row(n);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL k7_early: got %b need 0", bus.res_valid); end
      send_row(6);
      drain();
      checks++; if (nw !== 2) begin errors++; $display("FAIL k7_count: got %0d need 2", nw); end
      checks++; if ({el(wv[1], 6, 6), el(wv[1], 0, 0)} !== 16'h6701) begin errors++; $display("FAIL k7_w1: got %h %h need 67 01", el(wv[1], 6, 6), el(wv[1], 0, 0)); end
      start(2'd2, 1'b1, 2'd0);
      for (int n = 0; n < 7; n++) send_row(n);
      drain();
      checks++; if ({nw[3:0], wl[0], el(wv[0], 6, 6)} !== {4'd1, 1'b1, 8'h66}) begin errors++; $display("FAIL k7s2: got count %0d last %b el %h need 1 1 66", nw, wl[0], el(wv[0], 6, 6)); end
   endtask
   task automatic test_backpressure_hold();
      logic [WW-1:0] save;
      start(2'd0, 1'b0, 2'd0);
      for (int n = 0; n < 3; n++) send_row(n);
      for (int i = 0; i < 10; i++) begin
         if (bus.res_valid && bus.res_col == 4'd2) begin
            bus.res_ready = 1'b0;
            break;
         end
         @(negedge clk);
      end
      save = bus.result;
      checks++; if ({bus.res_col, el(save, 0, 0)} !== {4'd2, 8'h02}) begin errors++; $display("FAIL bp_reach: got col %0d el %h need 2 02", bus.res_col, el(save, 0, 0)); end
      repeat (3) begin
         @(negedge clk);
         checks++; if ({bus.res_valid, bus.res_col, bus.res_last} !== {1'b1, 4'd2, 1'b0} || bus.result !== save) begin errors++; $display("FAIL bp_stable: got valid %b col %0d last %b need 1 2 0", bus.res_valid, bus.res_col, bus.res_last); end
      end
      bus.ctrl = 2'd2;
      repeat (4) begin
         @(negedge clk);
         checks++; if ({bus.res_valid, bus.i_ready, bus.res_last} !== 3'b000) begin errors++; $display("FAIL hold_quiet: got %b need 000", {bus.res_valid, bus.i_ready, bus.res_last}); end
      end
      bus.ctrl = 2'd1;
      @(negedge clk);
      checks++; if ({bus.res_valid, bus.res_col} !== {1'b1, 4'd2} || bus.result !== save) begin errors++; $display("FAIL hold_resume: got valid %b col %0d need 1 2", bus.res_valid, bus.res_col); end
      drain();
      checks++; if ({nw[3:0], wc[0]} !== {4'd4, 4'd2}) begin errors++; $display("FAIL hold_rest: got count %0d first col %0d need 4 2", nw, wc[0]); end
   endtask
   task automatic test_flush();
      start(2'd0, 1'b0, 2'd0);
      for (int n = 0; n < 3; n++) send_row(n);
      drain();
      send_row(3);
      checks++; if ({bus.res_valid, bus.res_row} !== {1'b1, 16'd1}) begin errors++; $display("FAIL flush_pre: got valid %b row %0d need 1 1", bus.res_valid, bus.res_row); end
      bus.ctrl = 2'd0;
      @(negedge clk);
      checks++; if ({bus.res_valid, bus.i_ready, bus.res_row} !== 18'd0) begin errors++; $display("FAIL flush_clear: got valid %b ready %b row %0d need 0 0 0", bus.res_valid, bus.i_ready, bus.res_row); end
      bus.ctrl = 2'd1;
      @(negedge clk);
      send_row(10);
      send_row(11);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL flush_refill: got valid %b need 0", bus.res_valid); end
      send_row(12);
      checks++; if ({bus.res_valid, el(bus.result, 0, 0)} !== {1'b1, 8'hA0}) begin errors++; $display("FAIL flush_band: got valid %b el %h need 1 a0", bus.res_valid, el(bus.result, 0, 0)); end
      drain();
   endtask
   task automatic test_rst_mid();
      start(2'd0, 1'b0, 2'd0);
      for (int n = 0; n < 3; n++) send_row(n);
      drain();
      @(negedge clk);
      bus.i_data = row(5);
      bus.i_valid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({bus.i_ready, bus.res_valid, bus.res_last, bus.res_col, bus.res_row} !== 23'd0) begin errors++; $display("FAIL rst_mid_flags: got %b need 0", {bus.i_ready, bus.res_valid, bus.res_last, bus.res_col, bus.res_row}); end
      checks++; if (bus.result !== '0) begin errors++; $display("FAIL rst_mid_result: got %h need 0", bus.result); end
      rst = 1'b0;
      bus.i_valid = 1'b0;
   endtask
   initial begin
      bus.ctrl = 2'd1;
      bus.Wsize = 2'd0;
      bus.stride = 1'b0;
      bus.RLPadding = 2'd0;
      bus.i_valid = 1'b1;
      bus.i_data = '0;
      bus.res_ready = 1'b1;
      test_reset();
      bus.i_valid = 1'b0;
      test_basic();
      test_padding();
      test_stride();
      test_big_kernels();
      test_backpressure_hold();
      test_flush();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
